// File: rtl/blit_reg_if.sv
// GPU register front end for the blitter address unit: decodes bus requests into load strobes and readback enables.
// Optional write-timeout in WAIT is enabled by defining BLIT_REG_TIMEOUT_EN.
module blit_reg_if #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wr,
   input  logic              req_rd,
   input  logic [31:0]       req_data,
   input  logic              blit_active,
   output logic              busy,
   output logic              ack,
   output logic              err,
   output logic [31:0]       wdata,
   output logic              a1baseld,
   output logic              a1flagld,
   output logic              a1winld,
   output logic              a1ptrld,
   output logic              a1stepld,
   output logic              a1stepfld,
   output logic              a1fracld,
   output logic              a1incld,
   output logic              a1incfld,
   output logic              a2baseld,
   output logic              a2flagld,
   output logic              a2winld,
   output logic              a2ptrld,
   output logic              a2stepld,
   output logic              load_strobe,
   output logic              a1posrd,
   output logic              a1posfrd,
   output logic              a2posrd
);

   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic [2:0] {IDLE, WSTB, WAIT, RD1, RD2, NACK} state_t;

   state_t      state;
   logic [13:0] wr_dec;
   logic [2:0]  rd_dec;
   logic [13:0] wr_sel;
   logic [13:0] ld_q;
   logic [2:0]  rd_q;
   logic        load_q;
   logic        ack_q;
   logic        busy_q;
   logic [31:0] wdata_q;
   logic [IDX_W-1:0] word_idx;
   logic        unused_addr_lsbs;

   assign word_idx         = req_addr[ADDR_W-1:2];
   assign unused_addr_lsbs = &{1'b0, req_addr[1:0]};

   // Write offsets 0x00..0x34 map one-to-one onto the 14 load strobes; only three offsets are readable.
   always_comb begin
      wr_dec = '0;
      rd_dec = '0;
      if (word_idx < IDX_W'(14))
         wr_dec = 14'(1) << word_idx;
      if (word_idx == IDX_W'(3))
         rd_dec = 3'b001;
      else if (word_idx == IDX_W'(6))
         rd_dec = 3'b010;
      else if (word_idx == IDX_W'(12))
         rd_dec = 3'b100;
   end

`ifdef BLIT_REG_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
   assign err = err_q;
`else
   localparam int unused_timeout = TIMEOUT;
   assign err = 1'b0;
`endif

   // All outputs are registered and set on the transition into the state that owns them.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_sel  <= '0;
         ld_q    <= '0;
         rd_q    <= '0;
         load_q  <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         wdata_q <= '0;
`ifdef BLIT_REG_TIMEOUT_EN
         wait_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_wr) begin
                  busy_q <= 1'b1;
                  if (|wr_dec) begin
                     wr_sel  <= wr_dec;
                     wdata_q <= req_data;
                     if (blit_active) begin
                        state <= WAIT;
`ifdef BLIT_REG_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                     end else begin
                        state  <= WSTB;
                        ld_q   <= wr_dec;
                        load_q <= 1'b1;
                        ack_q  <= 1'b1;
                     end
                  end else begin
                     state <= NACK;
                     ack_q <= 1'b1;
                  end
               end else if (req_rd) begin
                  busy_q <= 1'b1;
                  if (|rd_dec) begin
                     state <= RD1;
                     rd_q  <= rd_dec;
                  end else begin
                     state <= NACK;
                     ack_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (!blit_active) begin
                  state  <= WSTB;
                  ld_q   <= wr_sel;
                  load_q <= 1'b1;
                  ack_q  <= 1'b1;
               end
`ifdef BLIT_REG_TIMEOUT_EN
               else if (wait_cnt == CNT_LIMIT) begin
                  state <= NACK;
                  ack_q <= 1'b1;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RD1: begin
               state <= RD2;
               ack_q <= 1'b1;
            end
            default: begin
               // WSTB, RD2 and NACK all last one cycle and drop everything on the way back to IDLE.
               state  <= IDLE;
               ld_q   <= '0;
               rd_q   <= '0;
               load_q <= 1'b0;
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
`ifdef BLIT_REG_TIMEOUT_EN
               err_q  <= 1'b0;
`endif
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign ack         = ack_q;
   assign wdata       = wdata_q;
   assign load_strobe = load_q;
   assign {a2stepld, a2ptrld, a2winld, a2flagld, a2baseld, a1incfld, a1incld,
           a1fracld, a1stepfld, a1stepld, a1ptrld, a1winld, a1flagld, a1baseld} = ld_q;
   assign {a2posrd, a1posfrd, a1posrd} = rd_q;

endmodule

// File: tb/tb_blit_reg_if.sv
// Directed bench for blit_reg_if: writes, deferred writes, reads, unmapped/collision, reset in WAIT, optional timeout.
module tb_blit_reg_if;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic [7:0]  req_addr;
   logic        req_wr;
   logic        req_rd;
   logic [31:0] req_data;
   logic        blit_active;
   logic        busy, ack, err;
   logic [31:0] wdata;
   logic a1baseld, a1flagld, a1winld, a1ptrld, a1stepld, a1stepfld, a1fracld;
   logic a1incld, a1incfld, a2baseld, a2flagld, a2winld, a2ptrld, a2stepld;
   logic load_strobe, a1posrd, a1posfrd, a2posrd;
   logic [13:0] ld;
   logic [2:0]  rd;

   int passed = 0;
   int total  = 0;

   assign ld = {a2stepld, a2ptrld, a2winld, a2flagld, a2baseld, a1incfld, a1incld,
                a1fracld, a1stepfld, a1stepld, a1ptrld, a1winld, a1flagld, a1baseld};
   assign rd = {a2posrd, a1posfrd, a1posrd};

`ifdef BLIT_REG_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 1023;
`endif

   blit_reg_if #(.ADDR_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
      .sys_clk(sys_clk), .reset(reset), .req_addr(req_addr), .req_wr(req_wr),
      .req_rd(req_rd), .req_data(req_data), .blit_active(blit_active),
      .busy(busy), .ack(ack), .err(err), .wdata(wdata),
      .a1baseld(a1baseld), .a1flagld(a1flagld), .a1winld(a1winld), .a1ptrld(a1ptrld),
      .a1stepld(a1stepld), .a1stepfld(a1stepfld), .a1fracld(a1fracld), .a1incld(a1incld),
      .a1incfld(a1incfld), .a2baseld(a2baseld), .a2flagld(a2flagld), .a2winld(a2winld),
      .a2ptrld(a2ptrld), .a2stepld(a2stepld), .load_strobe(load_strobe),
      .a1posrd(a1posrd), .a1posfrd(a1posfrd), .a2posrd(a2posrd)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_wr = 1'b0;
      req_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; blit_active = 1'b0; req_addr = '0; req_data = '0;
      idle_inputs();
      tick(); tick();
      reset = 1'b0;
      total++;
      if ({busy, ack, err, load_strobe, ld, rd} !== 21'd0)
         $display("[TB] FAIL reset_ctrl: got %0h expected 0", {busy, ack, err, load_strobe, ld, rd});
      else passed++;
      total++;
      if (wdata !== 32'd0) $display("[TB] FAIL reset_wdata: got %0h expected 0", wdata);
      else passed++;
   endtask

   task automatic test_write_idle();
      req_addr = 8'h24; req_data = 32'h0012_3400; req_wr = 1'b1; blit_active = 1'b0;
      tick();
      idle_inputs();
      total++;
      if (ld !== 14'h0200) $display("[TB] FAIL wr_strobe: got %0h expected 200", ld);
      else passed++;
      total++;
      if ({load_strobe, ack, busy, rd} !== 6'b111000)
         $display("[TB] FAIL wr_ack: got %0b expected 111000", {load_strobe, ack, busy, rd});
      else passed++;
      total++;
      if (wdata !== 32'h0012_3400) $display("[TB] FAIL wr_data: got %0h expected 123400", wdata);
      else passed++;
      tick();
      total++;
      if ({busy, ack, load_strobe, ld} !== 17'd0)
         $display("[TB] FAIL wr_done: got %0h expected 0", {busy, ack, load_strobe, ld});
      else passed++;
   endtask

   task automatic test_deferred_write();
      int stray = 0;
      blit_active = 1'b1;
      req_addr = 8'h0C; req_data = 32'h0005_0010; req_wr = 1'b1;
      tick();
      idle_inputs();
      total++;
      if (busy !== 1'b1) $display("[TB] FAIL defer_busy: got %0b expected 1", busy);
      else passed++;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            req_addr = 8'h18; req_rd = 1'b1;
         end else begin
            req_rd = 1'b0;
         end
         if (ld != 0 || load_strobe || ack || rd != 0) stray++;
         tick();
      end
      req_rd = 1'b0;
      total++;
      if (stray !== 0) $display("[TB] FAIL defer_quiet: got %0d active cycles expected 0", stray);
      else passed++;
      blit_active = 1'b0;
      tick();
      total++;
      if ({ld, load_strobe, ack} !== {14'h0008, 2'b11})
         $display("[TB] FAIL defer_strobe: got %0h expected %0h", {ld, load_strobe, ack}, {14'h0008, 2'b11});
      else passed++;
      total++;
      if (wdata !== 32'h0005_0010) $display("[TB] FAIL defer_data: got %0h expected 50010", wdata);
      else passed++;
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack || rd != 0 || busy) stray++;
      end
      total++;
      if (stray !== 0) $display("[TB] FAIL busy_read_lost: got %0d active cycles expected 0", stray);
      else passed++;
   endtask

   task automatic test_read();
      blit_active = 1'b1;
      req_addr = 8'h18; req_rd = 1'b1;
      tick();
      idle_inputs();
      total++;
      if ({rd, ack, load_strobe, ld, busy} !== {3'b010, 2'b00, 14'd0, 1'b1})
         $display("[TB] FAIL rd_cycle1: got %0h expected %0h", {rd, ack, load_strobe, ld, busy}, {3'b010, 2'b00, 14'd0, 1'b1});
      else passed++;
      tick();
      total++;
      if ({rd, ack, load_strobe, ld} !== {3'b010, 1'b1, 1'b0, 14'd0})
         $display("[TB] FAIL rd_cycle2: got %0h expected %0h", {rd, ack, load_strobe, ld}, {3'b010, 1'b1, 1'b0, 14'd0});
      else passed++;
      tick();
      total++;
      if ({rd, ack, busy} !== 5'd0) $display("[TB] FAIL rd_done: got %0b expected 0", {rd, ack, busy});
      else passed++;
      blit_active = 1'b0;
   endtask

   task automatic test_unmapped_and_collision();
      req_addr = 8'h40; req_data = 32'hDEAD_BEEF; req_wr = 1'b1;
      tick();
      idle_inputs();
      total++;
      if ({ack, busy, load_strobe, ld, rd} !== {2'b11, 18'd0})
         $display("[TB] FAIL unmapped_wr: got %0h expected %0h", {ack, busy, load_strobe, ld, rd}, {2'b11, 18'd0});
      else passed++;
      tick();
      req_addr = 8'h3C; req_rd = 1'b1;
      tick();
      idle_inputs();
      total++;
      if ({ack, rd} !== 4'b1000) $display("[TB] FAIL unmapped_rd: got %0b expected 1000", {ack, rd});
      else passed++;
      tick();
      req_addr = 8'h31; req_data = 32'h0000_0777; req_wr = 1'b1; req_rd = 1'b1;
      tick();
      idle_inputs();
      total++;
      if ({ld, rd, ack} !== {14'h1000, 3'b000, 1'b1})
         $display("[TB] FAIL collision: got %0h expected %0h", {ld, rd, ack}, {14'h1000, 3'b000, 1'b1});
      else passed++;
      tick();
      tick();
      total++;
      if ({rd, ack, busy} !== 5'd0) $display("[TB] FAIL collision_no_rd: got %0b expected 0", {rd, ack, busy});
      else passed++;
   endtask

   task automatic test_reset_in_wait();
      int stray = 0;
      blit_active = 1'b1;
      req_addr = 8'h00; req_data = 32'h1111_2222; req_wr = 1'b1;
      tick();
      idle_inputs();
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      blit_active = 1'b0;
      total++;
      if (busy !== 1'b0) $display("[TB] FAIL rst_wait_busy: got %0b expected 0", busy);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ld != 0 || ack || load_strobe) stray++;
      end
      total++;
      if (stray !== 0) $display("[TB] FAIL rst_wait_drop: got %0d active cycles expected 0", stray);
      else passed++;
   endtask

`ifdef BLIT_REG_TIMEOUT_EN
   task automatic test_timeout();
      int early = 0;
      blit_active = 1'b1;
      req_addr = 8'h04; req_data = 32'h0000_00AA; req_wr = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         if (ack || err) early++;
         tick();
      end
      if (ack || err) early++;
      total++;
      if (early !== 0) $display("[TB] FAIL timeout_early: got %0d cycles expected 0", early);
      else passed++;
      tick();
      total++;
      if ({ack, err, load_strobe, ld} !== {2'b11, 15'd0})
         $display("[TB] FAIL timeout_drop: got %0h expected %0h", {ack, err, load_strobe, ld}, {2'b11, 15'd0});
      else passed++;
      tick();
      total++;
      if ({ack, err, busy} !== 3'd0) $display("[TB] FAIL timeout_done: got %0b expected 0", {ack, err, busy});
      else passed++;
      req_wr = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 7; i++) tick();
      blit_active = 1'b0;
      tick();
      total++;
      if ({ld, ack, err} !== {14'h0002, 2'b10})
         $display("[TB] FAIL timeout_race: got %0h expected %0h", {ld, ack, err}, {14'h0002, 2'b10});
      else passed++;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_write_idle();
      test_deferred_write();
      test_read();
      test_unmapped_and_collision();
      test_reset_in_wait();
`ifdef BLIT_REG_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
